// File: rtl/led_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// display-source encodings and the all-dark patterns.
package led_pkg;

  // Display source encodings on disp_sel
  localparam logic [1:0] SEL_LED     = 2'd0;
  localparam logic [1:0] SEL_TOTAL   = 2'd1;
  localparam logic [1:0] SEL_CONDI   = 2'd2;
  localparam logic [1:0] SEL_UNCONDI = 2'd3;

  // Everything off on a common-anode display
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low gfedcba glyphs for hex digits 0..F
  localparam logic [6:0] HEX7_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg7
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/led_scan_driver.sv
// Scans a once-per-frame snapshot of one of four 32-bit core values onto
// an 8-digit common-anode display. The decimal point of digit N is lit when
// source N is the one being shown.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int CLK_DIV      = 4096,
  parameter int BLANK_CYCLES = 16,
  parameter int DIGITS       = 8
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [1:0]  disp_sel,
  input  logic        freeze,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      snapshot;
  logic [1:0]       shown_sel;

  logic             slot_end;
  logic             frame_end;
  logic             blank;
  logic             dp_n;
  logic [31:0]      source;
  logic [3:0]       nibble;
  logic [6:0]       glyph;

  assign slot_end  = (cnt == CNT_W'(CLK_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));
  // Leading part of every slot is dark so the previous digit never ghosts
  assign blank     = (cnt < CNT_W'(BLANK_CYCLES));
  assign nibble    = 4'(snapshot >> {idx, 2'b00});
  assign dp_n      = (idx != IDX_W'(shown_sel));

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Pick the live value that would be captured at the next frame boundary
  always_comb begin
    source = led_data_in;
    case (disp_sel)
      SEL_LED:     source = led_data_in;
      SEL_TOTAL:   source = total_cycles;
      SEL_CONDI:   source = condi_branch_num;
      SEL_UNCONDI: source = uncondi_branch_num;
      default:     source = led_data_in;
    endcase
  end

  // Prescaler and digit index: one slot per CLK_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Snapshot only at frame boundaries so a number is never torn mid-frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot  <= 32'h0;
      shown_sel <= SEL_LED;
    end else if (frame_end && !freeze) begin
      snapshot  <= source;
      shown_sel <= disp_sel;
    end
  end

  // Registered pin drivers, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_out  <= AN_OFF;
      seg_out <= SEG_OFF;
    end else if (blank) begin
      an_out  <= AN_OFF;
      seg_out <= SEG_OFF;
    end else begin
      an_out  <= ~(8'b1 << idx);
      seg_out <= {dp_n, glyph};
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver with CLK_DIV=4, BLANK_CYCLES=1.
// Edge k (counted from reset release) sees pre-edge cnt=(k-1)%4 and
// idx=((k-1)/4)%8; frame boundaries fall on edges that are multiples of 32.
module tb_led_scan_driver;

  logic        clk;
  logic        rst;
  logic [31:0] led_data_in;
  logic [31:0] total_cycles;
  logic [31:0] condi_branch_num;
  logic [31:0] uncondi_branch_num;
  logic [1:0]  disp_sel;
  logic        freeze;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int ecount;

  led_scan_driver #(
    .CLK_DIV      (4),
    .BLANK_CYCLES (1),
    .DIGITS       (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .led_data_in        (led_data_in),
    .total_cycles       (total_cycles),
    .condi_branch_num   (condi_branch_num),
    .uncondi_branch_num (uncondi_branch_num),
    .disp_sel           (disp_sel),
    .freeze             (freeze),
    .seg_out            (seg_out),
    .an_out             (an_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) ecount <= 0;
    else      ecount <= ecount + 1;
  end

  typedef struct {
    int          k;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [1:0]  sel;
    logic        frz;
    logic [31:0] led;
  } vec_t;

  vec_t tbl [23];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Advance to just after edge k; an overrun of the cycle budget is a failure
  task automatic wait_edge(input int k);
    int guard = 0;
    while (ecount < k && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (ecount != k) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_edge: at edge %0d, wanted %0d", ecount, k);
    end
  endtask

  initial begin
    logic [31:0] m_snap;
    logic [1:0]  m_sel;
    logic [31:0] src;
    logic [7:0]  exp_an, exp_seg, prev_an;
    logic [2:0]  ix;
    int          fe_entries;

    tbl[0]  = '{1,   8'hFF, 8'hFF, 2'd0, 1'b0, 32'h0000_00A1};
    tbl[1]  = '{2,   8'hFE, 8'h40, 2'd0, 1'b0, 32'h0000_00A1};
    tbl[2]  = '{6,   8'hFD, 8'hC0, 2'd0, 1'b0, 32'h0000_00A1};
    tbl[3]  = '{33,  8'hFF, 8'hFF, 2'd0, 1'b0, 32'h0000_00A1};
    tbl[4]  = '{34,  8'hFE, 8'h79, 2'd0, 1'b0, 32'h0000_00A1};
    tbl[5]  = '{38,  8'hFD, 8'h88, 2'd0, 1'b0, 32'h0000_00A1};
    tbl[6]  = '{40,  8'hFD, 8'h88, 2'd1, 1'b0, 32'h0000_00A1};
    tbl[7]  = '{46,  8'hF7, 8'hC0, 2'd1, 1'b0, 32'h0000_00A1};
    tbl[8]  = '{62,  8'h7F, 8'hC0, 2'd1, 1'b0, 32'h0000_00A1};
    tbl[9]  = '{66,  8'hFE, 8'h80, 2'd1, 1'b0, 32'h0000_00A1};
    tbl[10] = '{70,  8'hFD, 8'h40, 2'd1, 1'b1, 32'hFFFF_FFFF};
    tbl[11] = '{98,  8'hFE, 8'h80, 2'd1, 1'b1, 32'hFFFF_FFFF};
    tbl[12] = '{102, 8'hFD, 8'h40, 2'd1, 1'b1, 32'hFFFF_FFFF};
    tbl[13] = '{130, 8'hFE, 8'h80, 2'd1, 1'b1, 32'hFFFF_FFFF};
    tbl[14] = '{162, 8'hFE, 8'h80, 2'd1, 1'b1, 32'hFFFF_FFFF};
    tbl[15] = '{166, 8'hFD, 8'h40, 2'd0, 1'b0, 32'hFFFF_FFFF};
    tbl[16] = '{194, 8'hFE, 8'h0E, 2'd0, 1'b0, 32'hFFFF_FFFF};
    tbl[17] = '{198, 8'hFD, 8'h8E, 2'd0, 1'b0, 32'hFFFF_FFFF};
    tbl[18] = '{222, 8'h7F, 8'h8E, 2'd2, 1'b0, 32'hFFFF_FFFF};
    tbl[19] = '{226, 8'hFE, 8'hA4, 2'd2, 1'b0, 32'hFFFF_FFFF};
    tbl[20] = '{234, 8'hFB, 8'h40, 2'd3, 1'b0, 32'hFFFF_FFFF};
    tbl[21] = '{258, 8'hFE, 8'hB0, 2'd3, 1'b0, 32'hFFFF_FFFF};
    tbl[22] = '{270, 8'hF7, 8'h40, 2'd3, 1'b0, 32'hFFFF_FFFF};

    led_data_in        = 32'h0000_00A1;
    total_cycles       = 32'h0000_0008;
    condi_branch_num   = 32'h0000_0002;
    uncondi_branch_num = 32'h0000_0003;
    disp_sel           = 2'd0;
    freeze             = 1'b0;
    rst                = 1'b1;

    // Reset asserted before any clock edge
    #2 rst = 1'b0;
    #1;
    check8("reset_an", an_out, 8'hFF);
    check8("reset_seg", seg_out, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed checkpoints: compare, then apply the next inputs
    for (int i = 0; i < 23; i++) begin
      wait_edge(tbl[i].k);
      check8($sformatf("vec%0d_an k=%0d", i, tbl[i].k), an_out, tbl[i].an);
      check8($sformatf("vec%0d_seg k=%0d", i, tbl[i].k), seg_out, tbl[i].seg);
      disp_sel    = tbl[i].sel;
      freeze      = tbl[i].frz;
      led_data_in = tbl[i].led;
    end

    // One full frame of anode scan, including the 7F -> FF -> FE wrap
    wait_edge(288);
    for (int k = 289; k <= 322; k++) begin
      @(posedge clk); #1;
      ix = 3'(((k - 1) / 4) % 8);
      exp_an = (((k - 1) % 4) == 0) ? 8'hFF : ~(8'b1 << ix);
      check8($sformatf("scan_an k=%0d", k), an_out, exp_an);
      n_cmp++;
      if (!$onehot0(~an_out)) begin
        n_fail++;
        $display("FAIL scan_onehot k=%0d: got %h, want at most one low bit", k, an_out);
      end
    end

    // 1000 frames against a reference model with random sources and select
    m_snap     = 32'h0000_0003;
    m_sel      = 2'd3;
    prev_an    = an_out;
    fe_entries = 0;
    for (int k = 323; k < 323 + 32000; k++) begin
      if ((k % 32) == 8) begin
        disp_sel           = 2'($urandom_range(0, 3));
        freeze             = ($urandom_range(0, 3) == 0);
        led_data_in        = $urandom;
        total_cycles       = $urandom;
        condi_branch_num   = $urandom;
        uncondi_branch_num = $urandom;
      end
      @(posedge clk); #1;
      ix = 3'(((k - 1) / 4) % 8);
      if (((k - 1) % 4) == 0) begin
        exp_an  = 8'hFF;
        exp_seg = 8'hFF;
      end else begin
        exp_an  = ~(8'b1 << ix);
        exp_seg = {(ix != {1'b0, m_sel}), hex7(4'(m_snap >> (4 * ix)))};
      end
      check8($sformatf("sb_an k=%0d", k), an_out, exp_an);
      check8($sformatf("sb_seg k=%0d", k), seg_out, exp_seg);
      if (prev_an == 8'hFF && an_out == 8'hFE) fe_entries++;
      prev_an = an_out;
      if ((k % 32) == 0 && !freeze) begin
        case (disp_sel)
          2'd0:    src = led_data_in;
          2'd1:    src = total_cycles;
          2'd2:    src = condi_branch_num;
          default: src = uncondi_branch_num;
        endcase
        m_snap = src;
        m_sel  = disp_sel;
      end
    end
    n_cmp++;
    if (fe_entries != 1000) begin
      n_fail++;
      $display("FAIL frame_count: got %0d, want 1000", fe_entries);
    end

    // Mid-scan reset darkens the display without a clock edge
    rst = 1'b0;
    #1;
    check8("midreset_an", an_out, 8'hFF);
    check8("midreset_seg", seg_out, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_edge(1);
    check8("rerun_an_k1", an_out, 8'hFF);
    check8("rerun_seg_k1", seg_out, 8'hFF);
    wait_edge(2);
    check8("rerun_an_k2", an_out, 8'hFE);
    check8("rerun_seg_k2", seg_out, 8'h40);
    wait_edge(6);
    check8("rerun_an_k6", an_out, 8'hFD);
    check8("rerun_seg_k6", seg_out, 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
